// File: rtl/mem_lsu_stage.sv
// MEM stage with load/store unit: forwards ALU results, runs byte/half/word
// loads and stores against a req/ack data memory, stalls upstream while an
// access is outstanding and registers the result toward WB.
module mem_lsu_stage #(
    parameter int ADDR_W   = 32,
    parameter int REG_AW   = 5,
    parameter int MAX_WAIT = 16
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              in_valid_i,
    input  logic [REG_AW-1:0] wd_i,
    input  logic              wreg_i,
    input  logic [31:0]       wdata_i,
    input  logic [3:0]        mem_op_i,
    input  logic [ADDR_W-1:0] mem_addr_i,
    input  logic [31:0]       mem_sdata_i,
    output logic              stall_o,
    output logic              dm_req_o,
    output logic              dm_we_o,
    output logic [ADDR_W-1:0] dm_addr_o,
    output logic [3:0]        dm_be_o,
    output logic [31:0]       dm_wdata_o,
    input  logic              dm_ack_i,
    input  logic [31:0]       dm_rdata_i,
    output logic              wb_valid_o,
    output logic [REG_AW-1:0] wd_o,
    output logic              wreg_o,
    output logic [31:0]       wdata_o,
    output logic              misalign_o,
    output logic              err_o
);
    localparam logic S_IDLE = 1'b0;
    localparam logic S_REQ  = 1'b1;

    localparam logic [3:0] OP_LB = 4'd1, OP_LBU = 4'd2, OP_LH = 4'd3, OP_LHU = 4'd4,
                           OP_LW = 4'd5, OP_SB  = 4'd6, OP_SH = 4'd7, OP_SW  = 4'd8;

    localparam int CNT_W = $clog2(MAX_WAIT + 2);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'((MAX_WAIT == 0) ? 0 : MAX_WAIT - 1);

    logic              r_state;
    logic [CNT_W-1:0]  r_cnt;
    logic [3:0]        r_op;
    logic [REG_AW-1:0] r_wd;
    logic              r_wreg;
    logic [ADDR_W-1:0] r_addr;
    logic [31:0]       r_sdata;

    logic w_in_byte, w_in_half, w_in_word, w_in_mem, w_in_misal;
    logic w_ld, w_timeout;
    logic [31:0] w_shift, w_ld_data;

    // Decode the incoming op: access size and alignment.
    always_comb begin
        w_in_byte  = (mem_op_i == OP_LB) || (mem_op_i == OP_LBU) || (mem_op_i == OP_SB);
        w_in_half  = (mem_op_i == OP_LH) || (mem_op_i == OP_LHU) || (mem_op_i == OP_SH);
        w_in_word  = (mem_op_i == OP_LW) || (mem_op_i == OP_SW);
        w_in_mem   = w_in_byte || w_in_half || w_in_word;
        w_in_misal = (w_in_half && mem_addr_i[0]) || (w_in_word && (mem_addr_i[1:0] != 2'b00));
    end

    // Memory-side request driven purely from the latched access.
    always_comb begin
        dm_req_o   = (r_state == S_REQ);
        dm_we_o    = (r_op == OP_SB) || (r_op == OP_SH) || (r_op == OP_SW);
        dm_addr_o  = {r_addr[ADDR_W-1:2], 2'b00};
        dm_be_o    = 4'b1111;
        dm_wdata_o = r_sdata;
        case (r_op)
            OP_LB, OP_LBU, OP_SB: begin
                dm_be_o    = 4'b0001 << r_addr[1:0];
                dm_wdata_o = {4{r_sdata[7:0]}};
            end
            OP_LH, OP_LHU, OP_SH: begin
                dm_be_o    = r_addr[1] ? 4'b1100 : 4'b0011;
                dm_wdata_o = {2{r_sdata[15:0]}};
            end
            default: ;
        endcase
    end

    // Lane selection and sign/zero extension of returned load data.
    always_comb begin
        w_ld      = (r_op >= OP_LB) && (r_op <= OP_LW);
        w_shift   = dm_rdata_i >> {r_addr[1:0], 3'b000};
        w_ld_data = dm_rdata_i;
        case (r_op)
            OP_LB:   w_ld_data = {{24{w_shift[7]}}, w_shift[7:0]};
            OP_LBU:  w_ld_data = {24'd0, w_shift[7:0]};
            OP_LH:   w_ld_data = {{16{w_shift[15]}}, w_shift[15:0]};
            OP_LHU:  w_ld_data = {16'd0, w_shift[15:0]};
            default: ;
        endcase
    end

    // Abort when this REQ cycle is the MAX_WAIT-th without ack; ack wins.
    always_comb begin
        w_timeout = (MAX_WAIT != 0) && (r_state == S_REQ) && !dm_ack_i && (r_cnt == CNT_LAST);
        if (r_state == S_IDLE)
            stall_o = in_valid_i && w_in_mem && !w_in_misal;
        else
            stall_o = !dm_ack_i && !w_timeout;
    end

    // FSM, wait counter, latched access and MEM/WB register.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state    <= S_IDLE;
            r_cnt      <= '0;
            r_op       <= '0;
            r_wd       <= '0;
            r_wreg     <= 1'b0;
            r_addr     <= '0;
            r_sdata    <= '0;
            wb_valid_o <= 1'b0;
            wd_o       <= '0;
            wreg_o     <= 1'b0;
            wdata_o    <= '0;
            misalign_o <= 1'b0;
            err_o      <= 1'b0;
        end else begin
            misalign_o <= 1'b0;
            err_o      <= 1'b0;
            if (r_state == S_IDLE) begin
                r_cnt <= '0;
                if (!in_valid_i) begin
                    wb_valid_o <= 1'b0;
                    wreg_o     <= 1'b0;
                end else if (!w_in_mem || w_in_misal) begin
                    wb_valid_o <= 1'b1;
                    wd_o       <= wd_i;
                    wreg_o     <= wreg_i && !w_in_mem;
                    wdata_o    <= wdata_i;
                    misalign_o <= w_in_mem;
                end else begin
                    r_state    <= S_REQ;
                    r_op       <= mem_op_i;
                    r_wd       <= wd_i;
                    r_wreg     <= wreg_i;
                    r_addr     <= mem_addr_i;
                    r_sdata    <= mem_sdata_i;
                    wb_valid_o <= 1'b0;
                    wreg_o     <= 1'b0;
                end
            end else begin
                if (dm_ack_i || w_timeout) begin
                    r_state    <= S_IDLE;
                    r_cnt      <= '0;
                    wb_valid_o <= 1'b1;
                    wd_o       <= r_wd;
                    wreg_o     <= dm_ack_i && w_ld && r_wreg;
                    wdata_o    <= (dm_ack_i && w_ld) ? w_ld_data : 32'd0;
                    err_o      <= !dm_ack_i;
                end else begin
                    r_cnt      <= r_cnt + 1'b1;
                    wb_valid_o <= 1'b0;
                    wreg_o     <= 1'b0;
                end
            end
        end
    end
endmodule

// File: doc/mem_lsu_stage.md
Name: mem_lsu_stage

Overview:
Parametrised successor to the pass-through MEM stage of the 5-stage MIPS pipeline. It sits between EX/MEM and MEM/WB. It forwards write-back info for ALU instructions and executes LB/LBU/LH/LHU/LW/SB/SH/SW against a data memory that uses a req/ack handshake of variable latency. It stalls upstream while an access is outstanding and registers its results toward WB.

Parameters:
ADDR_W, 32, byte-address width of mem_addr_i and dm_addr_o.
REG_AW, 5, register-index width (wd_i/wd_o).
MAX_WAIT, 16, number of REQ cycles without ack before abort; 0 = never abort.
(Data path is fixed at 32 bits with 4 byte lanes.)

Ports:
clk  in  1  clock, rising edge
rst  in  1  synchronous, active-high reset
in_valid_i  in  1  EX/MEM slot holds an instruction
wd_i  in  REG_AW  destination register
wreg_i  in  1  write-enable request
wdata_i  in  32  ALU result (ignored for loads)
mem_op_i  in  4  0 none, 1 LB, 2 LBU, 3 LH, 4 LHU, 5 LW, 6 SB, 7 SH, 8 SW; 9-15 treated as none
mem_addr_i  in  ADDR_W  effective byte address
mem_sdata_i  in  32  store data (low-aligned)
stall_o  out  1  upstream must hold inputs
dm_req_o  out  1  memory request
dm_we_o  out  1  1 = store
dm_addr_o  out  ADDR_W  word address, low 2 bits = 0
dm_be_o  out  4  byte enables
dm_wdata_o  out  32  lane-replicated store data
dm_ack_i  in  1  request completes this cycle
dm_rdata_i  in  32  load data, valid with ack
wb_valid_o  out  1  MEM/WB register holds a result
wd_o  out  REG_AW  registered
wreg_o  out  1  registered
wdata_o  out  32  registered
misalign_o  out  1  1-cycle pulse on a misaligned access
err_o  out  1  1-cycle pulse on a timeout abort

Behaviour:
- Reset (rst=1 at an edge): state IDLE; wait counter 0; wb_valid_o, wd_o, wreg_o, wdata_o, misalign_o and err_o are all 0. dm_req_o=0 in the following cycle. Reset mid-REQ drops the request with no write-back.
- FSM has two states, IDLE and REQ.
- IDLE, in_valid_i=0: next edge sets wb_valid_o=0 and wreg_o=0.
- IDLE, op none: next edge loads wd/wreg/wdata into the outputs and sets wb_valid_o=1. stall_o=0. Latency is 1 cycle.
- IDLE, mem op misaligned (halfword with addr[0]=1; word with addr[1:0]!=0):
  - no request is issued; stall_o=0;
  - next edge sets wb_valid_o=1, wreg_o=0, misalign_o=1.
- IDLE, aligned mem op:
  - stall_o=1 combinationally in that cycle;
  - the edge latches op, wd_i, wreg_i, addr and sdata, then moves to REQ.
- REQ:
  - dm_req_o=1; dm_addr_o, dm_be_o, dm_we_o and dm_wdata_o come from the latched values and stay stable until ack.
  - Inputs are ignored; stall_o = !dm_ack_i.
- Ack in REQ (possible in the first REQ cycle):
  - next edge sets wb_valid_o=1 and returns to IDLE;
  - load: wreg_o=latched wreg, wdata_o=extracted data;
  - store: wreg_o=0.
  - Minimum memory-op latency: accept cycle + 1 REQ cycle.
- Timeout: the counter increments for each REQ cycle without ack. When the count reaches MAX_WAIT (and MAX_WAIT!=0):
  - dm_req_o drops next cycle and the FSM returns to IDLE;
  - err_o=1 for one cycle; wb_valid_o=1, wreg_o=0; stall_o=0 in the abort cycle.
- Ack and timeout in the same cycle: ack wins.
- Byte enables and store data:
  - byte ops: be = 1<<addr[1:0]; store data = {4{sdata[7:0]}};
  - half ops: be = addr[1] ? 1100 : 0011; store data = {2{sdata[15:0]}};
  - word ops: be = 1111; store data = sdata.
  - dm_be_o is driven for loads too.
- Load extraction: select the lane by latched addr[1:0]. LB/LH sign-extend; LBU/LHU zero-extend; LW returns the full word.
- misalign_o and err_o are 0 in every cycle other than their single pulse.

Test Plan:
- Pass-through: op=0, wd=5, wreg=1, wdata=0xDEADBEEF -> next edge: wd_o=5, wreg_o=1, wdata_o=0xDEADBEEF, wb_valid_o=1, stall_o=0 throughout.
- LB then LBU at addr 0x13, rdata 0x80112233 returned with ack in the first REQ cycle:
  - dm_addr_o=0x10, be=1000, stall_o high 1 cycle;
  - LB: wdata_o=0xFFFFFF80; LBU: 0x00000080; both land 2 edges after accept.
- SH at addr 0x102, sdata 0x0000ABCD, ack after 3 non-ack REQ cycles:
  - dm_we_o=1, dm_addr_o=0x100, be=1100, dm_wdata_o=0xABCDABCD;
  - stall_o high 4 cycles; then wb_valid_o=1, wreg_o=0.
- LW at addr 0x101 -> dm_req_o never asserted, misalign_o pulse, wreg_o=0, no stall.
- MAX_WAIT=16, ack never asserted -> dm_req_o held 16 cycles, err_o one pulse, FSM back in IDLE, next ALU op passes normally.
- rst asserted in the 2nd REQ cycle of an LW -> next cycle dm_req_o=0, all outputs 0; a late ack is ignored.
